// File: rtl/bounded_wrap_counter_mc_if.sv
// Control and status bundle for bounded_wrap_counter_mc: per-channel enables,
// bound-load strobe and the packed counter/bound/wrap outputs.
interface bounded_wrap_counter_mc_if #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]       en;
  logic [1:0]           mode;
  logic                 load;
  logic [CHW-1:0]       load_ch;
  logic [WIDTH-1:0]     load_val;
  logic [NCH*WIDTH-1:0] c;
  logic [NCH*WIDTH-1:0] n;
  logic [NCH-1:0]       wrap;
  logic                 inv_err;

  modport master (
    output en, mode, load, load_ch, load_val,
    input  c, n, wrap, inv_err
  );

  modport slave (
    input  en, mode, load, load_ch, load_val,
    output c, n, wrap, inv_err
  );
endinterface

// File: rtl/bounded_wrap_counter_mc.sv
// Multi-channel bounded counter: each channel counts against its own programmable
// bound in wrap-to-1, wrap-to-0, saturate or count-down mode, with a sticky c>n flag.
module bounded_wrap_counter_mc #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned NCH         = 4,
  parameter int unsigned RESET_BOUND = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  bounded_wrap_counter_mc_if.slave  bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    M_WRAP1 = 2'd0,
    M_WRAP0 = 2'd1,
    M_SAT   = 2'd2,
    M_DOWN  = 2'd3
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] c_q [NCH];
  logic [WIDTH-1:0] n_q [NCH];
  logic [NCH-1:0]   wrap_q;
  logic             inv_q;
  logic             viol;

  assign mode = mode_t'(bus.mode);

  always_comb begin
    viol = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (c_q[i] > n_q[i]) viol = 1'b1;
    end
  end

  always_comb begin
    bus.c = '0;
    bus.n = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.c[i*WIDTH +: WIDTH] = c_q[i];
      bus.n[i*WIDTH +: WIDTH] = n_q[i];
    end
    bus.wrap    = wrap_q;
    bus.inv_err = inv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        c_q[i] <= '0;
        n_q[i] <= WIDTH'(RESET_BOUND);
      end
      wrap_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      inv_q <= inv_q | viol;
      for (int unsigned i = 0; i < NCH; i++) begin
        wrap_q[i] <= 1'b0;
        // Out-of-range load_ch never matches any i, so such loads are dropped.
        if (bus.load && (bus.load_ch == CHW'(i))) begin
          n_q[i] <= bus.load_val;
          c_q[i] <= '0;
        end else if (n_q[i] == '0) begin
          c_q[i] <= '0;
        end else if (bus.en[i]) begin
          unique case (mode)
            M_WRAP1: begin
              if (c_q[i] == n_q[i]) begin
                c_q[i]    <= ONE;
                wrap_q[i] <= 1'b1;
              end else begin
                c_q[i] <= c_q[i] + ONE;
              end
            end
            M_WRAP0: begin
              if (c_q[i] == n_q[i]) begin
                c_q[i]    <= '0;
                wrap_q[i] <= 1'b1;
              end else begin
                c_q[i] <= c_q[i] + ONE;
              end
            end
            M_SAT: begin
              if (c_q[i] < n_q[i]) begin
                c_q[i]    <= c_q[i] + ONE;
                wrap_q[i] <= ((c_q[i] + ONE) == n_q[i]);
              end
            end
            M_DOWN: begin
              if (c_q[i] == '0) begin
                c_q[i]    <= n_q[i];
                wrap_q[i] <= 1'b1;
              end else begin
                c_q[i] <= c_q[i] - ONE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/bounded_wrap_counter_mc.md
Name: bounded_wrap_counter_mc

Overview:
- Multi-channel bounded counter: NCH independent counters c[i], each limited by its own run-time programmable bound n[i].
- Mode selects wrap-to-1, wrap-to-0, saturate or count-down behaviour.
- Each channel emits a registered wrap pulse; the block also flags any violation of the c<=n invariant.
- Generalised successor of the team's single-channel fixed-bound selector counter. Used as a property-mining/invariant target and as a reusable event/period counter.

Parameters:
- WIDTH, 11, bit width of each counter and bound.
- NCH, 4, number of independent channels (1..16).
- RESET_BOUND, 200, value loaded into every n[i] at reset; must be < 2^WIDTH.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  NCH  per-channel count enable (the former "selector").
- mode  in  2  global mode: 0=WRAP1, 1=WRAP0, 2=SAT, 3=DOWN.
- load  in  1  bound-load strobe, one channel per cycle.
- load_ch  in  clog2(NCH) (min 1)  channel addressed by load.
- load_val  in  WIDTH  new bound for load_ch.
- c  out  NCH*WIDTH  counter values, channel i at bits [i*WIDTH +: WIDTH], registered.
- n  out  NCH*WIDTH  bound values, same packing, registered.
- wrap  out  NCH  one-cycle pulse per channel, registered.
- inv_err  out  1  sticky flag: some c[i] > n[i].

Behaviour:
- Reset (rst=1 at posedge): every c[i]=0, n[i]=RESET_BOUND, wrap=0, inv_err=0. Reset overrides load and en.
- Per channel i, evaluated each posedge when rst=0, in priority order:
  1. Load: load=1 and load_ch==i → n[i]<=load_val, c[i]<=0, wrap[i]<=0, regardless of en[i]. If load_ch>=NCH the load is ignored.
  2. Zero bound: n[i]==0 → c[i] held at 0, wrap[i]<=0, in every mode.
  3. Hold: en[i]=0 → c[i], n[i] held, wrap[i]<=0.
  4. Count: en[i]=1 applies the mode rules below.
- Mode rules when counting:
  - WRAP1: c!=n → c+1, wrap 0; c==n → c<=1, wrap<=1. This is the legacy sequence 0,1..n,1..n.
  - WRAP0: c!=n → c+1; c==n → c<=0, wrap<=1.
  - SAT: c<n → c+1, wrap<=1 only on the step that reaches n; c==n → hold, wrap 0.
  - DOWN: c!=0 → c-1, wrap 0; c==0 → c<=n, wrap<=1.
- Every change in c, n and wrap is visible the cycle after the enabling edge (latency 1). wrap rises in the same cycle c shows its post-wrap value.
- Mode may change on any cycle and takes effect at the next edge using the current c and n.
- Arithmetic is unsigned WIDTH-bit. c==n is always tested before increment, so c+1 never overflows while the invariant holds.
- Invariant: c[i] <= n[i] at all times. Reset, load (c<=0) and the rules above guarantee this.
- inv_err: set on the cycle after any c[i]>n[i] is observed. Stays set until rst. It must never assert in correct operation and exists for formal/sim checking. Its assertion form must be a property in the testbench.
- n[i] changes only through reset or load.
- Channels are fully independent; a load to one channel does not affect the others.

Test Plan:
- Reset, then en[0]=1 for 202 cycles with mode=WRAP1 → c0 runs 0,1..200, then 1; wrap[0]=1 exactly on the cycle c0 shows 1 after 200. Other channels stay at 0.
- load ch1 with 3, mode=WRAP0, en[1]=1 for 9 cycles → c1 runs 0,1,2,3,0,1,2,3,0; wrap[1] high twice. Assert load and en[1] together → load wins and c1=0.
- mode=SAT, bound 5 → c reaches 5 and holds; wrap pulses once. Switching to WRAP1 next cycle → c=1 with wrap.
- mode=DOWN, bound 4 from c=0 → c runs 4,3,2,1,0,4; wrap on each reload to 4.
- Load ch2 with 0 → c2 stays 0 under en in all four modes, no wrap. Load with load_ch>=NCH → no state change on any channel.
- Assert rst mid-count (c0=150) while load is also asserted → all c=0, n=RESET_BOUND, wrap=0. inv_err stays 0 across all scenarios, including random en/mode/load runs of 10k cycles.
